// File: rtl/mdc_delay_commutator_pkg.sv
// Shared helpers for the MDC delay-commutator.
// No ports; provides the block-counter width calculation.
package mdc_delay_commutator_pkg;

    // Width of a counter that spans DEPTH positions. A width of at least 1
    // keeps DEPTH=1 legal even though the counter is then constant 0.
    function automatic int cnt_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mdc_delay_commutator_if.sv
// Sample/pair bus of the delay-commutator.
// Ports (signals): in_valid, flush, a_re/a_im, b_re/b_im  (towards the DUT)
//                  out_valid, x_re/x_im, y_re/y_im      (from the DUT)
// master = sample source / pair sink, slave = the commutator.
interface mdc_delay_commutator_if #(
    parameter int WIDTH = 9
);
    logic             in_valid;
    logic             flush;
    logic [WIDTH-1:0] a_re;
    logic [WIDTH-1:0] a_im;
    logic [WIDTH-1:0] b_re;
    logic [WIDTH-1:0] b_im;
    logic             out_valid;
    logic [WIDTH-1:0] x_re;
    logic [WIDTH-1:0] x_im;
    logic [WIDTH-1:0] y_re;
    logic [WIDTH-1:0] y_im;

    modport master (
        output in_valid, flush, a_re, a_im, b_re, b_im,
        input  out_valid, x_re, x_im, y_re, y_im
    );

    modport slave (
        input  in_valid, flush, a_re, a_im, b_re, b_im,
        output out_valid, x_re, x_im, y_re, y_im
    );
endinterface

// File: rtl/mdc_delay_commutator_delay_line.sv
// delay_line_en: enable-gated complex shift register, DEPTH entries deep.
// Ports: clk, rst (sync, active-high, clears all entries), en (shift one
//        place), di_re/di_im (input sample), do_re/do_im (sample that
//        entered DEPTH enables ago).
module delay_line_en #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);
    logic [WIDTH-1:0] re_q [DEPTH];
    logic [WIDTH-1:0] im_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                re_q[i] <= '0;
                im_q[i] <= '0;
            end
        end else if (en) begin
            re_q[0] <= di_re;
            im_q[0] <= di_im;
            for (int i = 1; i < DEPTH; i++) begin
                re_q[i] <= re_q[i-1];
                im_q[i] <= im_q[i-1];
            end
        end
    end

    assign do_re = re_q[DEPTH-1];
    assign do_im = im_q[DEPTH-1];
endmodule

// File: rtl/mdc_delay_commutator.sv
// Two-lane complex delay-commutator for a radix-2 MDC FFT stage.
// Lane A goes through DL1, a swap switch exchanges lanes every DEPTH
// accepted samples, the bottom lane goes through DL2. Each output pair
// holds two same-lane samples DEPTH accepts apart.
// Ports: clk, rst (sync, active-high)
//        bus (slave): in_valid, flush, a_*/b_* in; out_valid, x_*/y_* out
module mdc_delay_commutator
    import mdc_delay_commutator_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    mdc_delay_commutator_if.slave  bus
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic             accept;
    logic             wrap;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_q, sel_d;
    logic             primed_q, primed_d;
    logic [WIDTH-1:0] ad_re, ad_im, bd_re, bd_im;
    logic [WIDTH-1:0] top_re, top_im, bot_re, bot_im;

    // rst priority is enforced inside every register block.
    assign accept = bus.in_valid & ~bus.flush;
    assign wrap   = (cnt_q == CNT_W'(DEPTH - 1));

    delay_line_en #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dl1 (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .di_re (bus.a_re),
        .di_im (bus.a_im),
        .do_re (ad_re),
        .do_im (ad_im)
    );

    always_comb begin
        top_re = sel_q ? bus.b_re : ad_re;
        top_im = sel_q ? bus.b_im : ad_im;
        bot_re = sel_q ? ad_re : bus.b_re;
        bot_im = sel_q ? ad_im : bus.b_im;
    end

    delay_line_en #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dl2 (
        .clk   (clk),
        .rst   (rst),
        .en    (accept),
        .di_re (bot_re),
        .di_im (bot_im),
        .do_re (bd_re),
        .do_im (bd_im)
    );

    always_comb begin
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        primed_d = primed_q;
        if (bus.flush) begin
            cnt_d    = '0;
            sel_d    = 1'b0;
            primed_d = 1'b0;
        end else if (bus.in_valid) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
            if (wrap) begin
                sel_d    = ~sel_q;
                primed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            sel_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            primed_q <= primed_d;
        end
    end

    // x/y hold across stalls and flushes; only out_valid drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.x_re      <= '0;
            bus.x_im      <= '0;
            bus.y_re      <= '0;
            bus.y_im      <= '0;
        end else if (accept) begin
            bus.out_valid <= primed_q;
            bus.x_re      <= bd_re;
            bus.x_im      <= bd_im;
            bus.y_re      <= top_re;
            bus.y_im      <= top_im;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
